c64_bus_ctrl: RTL and testbench

//  CPU-side memory/bus controller, directly downstream of the 6502 core: consumes ab/do/we, returns di.

---
 rtl/c64_bus_ctrl_if.sv | 38 +++
 rtl/c64_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_c64_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c64_bus_ctrl_if.sv
// c64_bus_ctrl_if: request/acknowledge handshake between the CPU bus controller and the
// memory-mapped I/O block behind the $D000-$DFFF window.
//
// Signals
//   io_req    controller -> device  request, held high until ack or timeout
//   io_we     controller -> device  write qualifier, valid while io_req is high
//   io_addr   controller -> device  window offset (CPU address [11:0]), latched at request
//   io_wdata  controller -> device  write data, latched at request
//   io_rdata  device -> controller  read data, valid in the io_ack cycle
//   io_ack    device -> controller  one-cycle completion pulse
//
// Modports: master (the bus controller), slave (the I/O device).
interface c64_bus_ctrl_if;
  logic        io_req;
  logic        io_we;
  logic [11:0] io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;

  modport master (
    output io_req,
    output io_we,
    output io_addr,
    output io_wdata,
    input  io_rdata,
    input  io_ack
  );

  modport slave (
    input  io_req,
    input  io_we,
    input  io_addr,
    input  io_wdata,
    output io_rdata,
    output io_ack
  );
endinterface

// File: rtl/c64_bus_ctrl.sv
// c64_bus_ctrl: CPU-side memory and bus controller sitting directly behind the 6502 core.
// Holds the 64 KiB RAM and the $0000/$0001 processor port, decodes the LORAM/HIRAM/CHAREN
// banking onto RAM, the external BASIC/KERNAL/CHAR ROMs or the I/O window, and runs a
// req/ack handshake (with timeout) for accesses to the visible I/O window.
//
// Build option
//   C64_PORT_EN  defined:   $0000 (DDR) / $0001 (port) are registers and drive the banking.
//                undefined: $0000/$0001 are plain RAM and banking is fixed to all-ones.
//
// Parameters
//   IO_TIMEOUT   cycles to wait for io_ack before completing with 8'hFF
//   PORT_RESET   reset value of the processor-port data register
//
// Ports
//   clk        in   system clock, everything on posedge
//   reset      in   synchronous active-high reset
//   cpu_ab     in   CPU address bus
//   cpu_do     in   CPU write data
//   cpu_we     in   CPU write enable
//   cpu_di     out  read data to CPU, combinational (zero read latency)
//   cpu_rdy    out  0 stalls the CPU while an I/O access is outstanding
//   rom_sel    out  0 none, 1 BASIC, 2 KERNAL, 3 CHAR
//   rom_addr   out  ROM offset (CHAR forces bit 12 low)
//   rom_data   in   asynchronous ROM read data
//   io         master side of the I/O handshake interface
module c64_bus_ctrl #(
  parameter int unsigned IO_TIMEOUT = 16,
  parameter logic [7:0]  PORT_RESET = 8'h37
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_ab,
  input  logic [7:0]            cpu_do,
  input  logic                  cpu_we,
  output logic [7:0]            cpu_di,
  output logic                  cpu_rdy,
  output logic [1:0]            rom_sel,
  output logic [12:0]           rom_addr,
  input  logic [7:0]            rom_data,
  c64_bus_ctrl_if.master        io
);

  localparam int unsigned       TimerW    = $clog2(IO_TIMEOUT) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(IO_TIMEOUT - 1);

  localparam logic [1:0] RomNone   = 2'd0;
  localparam logic [1:0] RomBasic  = 2'd1;
  localparam logic [1:0] RomKernal = 2'd2;
  localparam logic [1:0] RomChar   = 2'd3;

  typedef enum logic [1:0] {
    SrcRam,
    SrcPort,
    SrcRom,
    SrcIo
  } src_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------------------
  // Handshake state
  // ---------------------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              rdy_q, rdy_d;
  logic              io_req_q, io_req_d;
  logic              io_we_q, io_we_d;
  logic [11:0]       io_addr_q, io_addr_d;
  logic [7:0]        io_wdata_q, io_wdata_d;
  logic [7:0]        io_hold_q, io_hold_d;

  // ---------------------------------------------------------------------------------------
  // Processor port and banking lines
  // ---------------------------------------------------------------------------------------
  logic       loram;
  logic       hiram;
  logic       charen;
  logic       is_port_reg;
  logic [7:0] port_rd;

`ifdef C64_PORT_EN
  logic [7:0] ddr_q;
  logic [7:0] port_q;
  logic [7:0] pins;

  // Port registers only update on a completed CPU write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ddr_q  <= 8'h2F;
      port_q <= PORT_RESET;
    end else if (cpu_we && rdy_q) begin
      if (cpu_ab == 16'h0000) begin
        ddr_q <= cpu_do;
      end
      if (cpu_ab == 16'h0001) begin
        port_q <= cpu_do;
      end
    end
  end

  // Lines configured as inputs float high through the pull-ups on bits 0-2 and 4.
  assign pins        = (port_q & ddr_q) | (~ddr_q & 8'h17);
  assign loram       = pins[0];
  assign hiram       = pins[1];
  assign charen      = pins[2];
  assign is_port_reg = (cpu_ab[15:1] == 15'h0000);
  assign port_rd     = cpu_ab[0] ? pins : ddr_q;
`else
  assign loram       = 1'b1;
  assign hiram       = 1'b1;
  assign charen      = 1'b1;
  assign is_port_reg = 1'b0;
  assign port_rd     = 8'h00;
`endif

  // ---------------------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------------------
  src_e src;

  always_comb begin
    src     = SrcRam;
    rom_sel = RomNone;
    if (is_port_reg) begin
      src = SrcPort;
    end else begin
      unique case (cpu_ab[15:12])
        4'hA, 4'hB: begin
          if (loram && hiram) begin
            src     = SrcRom;
            rom_sel = RomBasic;
          end
        end
        4'hD: begin
          if (loram || hiram) begin
            if (charen) begin
              src = SrcIo;
            end else begin
              src     = SrcRom;
              rom_sel = RomChar;
            end
          end
        end
        4'hE, 4'hF: begin
          if (hiram) begin
            src     = SrcRom;
            rom_sel = RomKernal;
          end
        end
        default: ;
      endcase
    end
  end

  // The character ROM is only 4 KiB, so its offset drops bit 12.
  assign rom_addr = (rom_sel == RomChar) ? {1'b0, cpu_ab[11:0]} : cpu_ab[12:0];

  // ---------------------------------------------------------------------------------------
  // RAM: not cleared by reset. ROM areas are write-through; I/O and port writes are not.
  // ---------------------------------------------------------------------------------------
  logic [7:0] ram_q [65536];
  logic       ram_we;

  assign ram_we = cpu_we && rdy_q && !reset && ((src == SrcRam) || (src == SrcRom));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[cpu_ab] <= cpu_do;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read mux, zero latency
  // ---------------------------------------------------------------------------------------
  always_comb begin
    cpu_di = 8'h00;
    unique case (src)
      SrcRam:  cpu_di = ram_q[cpu_ab];
      SrcPort: cpu_di = port_rd;
      SrcRom:  cpu_di = rom_data;
      SrcIo:   cpu_di = io_hold_q;
      default: cpu_di = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // I/O handshake FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      rdy_q      <= 1'b1;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 12'h000;
      io_wdata_q <= 8'h00;
      io_hold_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rdy_q      <= rdy_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_hold_q  <= io_hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rdy_d      = rdy_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_hold_d  = io_hold_q;

    unique case (state_q)
      StIdle: begin
        if ((src == SrcIo) && rdy_q) begin
          io_we_d    = cpu_we;
          io_addr_d  = cpu_ab[11:0];
          io_wdata_d = cpu_do;
          io_req_d   = 1'b1;
          rdy_d      = 1'b0;
          timer_d    = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        // An ack arriving on the last timeout cycle still delivers its data.
        if (io.io_ack) begin
          io_hold_d = io.io_rdata;
          io_req_d  = 1'b0;
          rdy_d     = 1'b1;
          state_d   = StDone;
        end else if (timer_q == TimerLast) begin
          io_hold_d = 8'hFF;
          io_req_d  = 1'b0;
          rdy_d     = 1'b1;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: begin
        // The CPU consumes io_hold this cycle; returning to idle (not re-arming) keeps the
        // still-presented address from issuing a second request.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cpu_rdy     = rdy_q;
  assign io.io_req   = io_req_q;
  assign io.io_we    = io_we_q;
  assign io.io_addr  = io_addr_q;
  assign io.io_wdata = io_wdata_q;

`ifndef SYNTHESIS
  // A request is outstanding exactly while the CPU is stalled.
  a_req_vs_rdy: assert property (@(posedge clk) disable iff (reset) (io_req_q != rdy_q));
  a_timer_bound: assert property (@(posedge clk) disable iff (reset)
                                  (state_q == StWait) |-> (timer_q <= TimerLast));
`endif

endmodule

// File: tb/tb_c64_bus_ctrl.sv
module tb_c64_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [1:0]  rom_sel;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;

  int checks = 0;
  int errors = 0;

  c64_bus_ctrl_if io_bus ();

  c64_bus_ctrl #(
    .IO_TIMEOUT(16),
    .PORT_RESET(8'h37)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_ab   (cpu_ab),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .cpu_di   (cpu_di),
    .cpu_rdy  (cpu_rdy),
    .rom_sel  (rom_sel),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .io       (io_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: per-ROM tag xor low address byte, so both selection and offset are visible.
  function automatic logic [7:0] rom_byte(input logic [1:0] sel, input logic [12:0] addr);
    logic [7:0] tag;
    case (sel)
      2'd1:    tag = 8'hB1;
      2'd2:    tag = 8'hE2;
      2'd3:    tag = 8'hC3;
      default: tag = 8'h00;
    endcase
    return tag ^ addr[7:0];
  endfunction

  assign rom_data = rom_byte(rom_sel, rom_addr);

  typedef struct {
    logic [15:0] ab;
    logic        we;
    logic [7:0]  wd;
    logic [1:0]  sel;
    logic [12:0] raddr;
    logic        chk_di;
    logic [7:0]  di;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] ab, input logic we, input logic [7:0] wd,
                              input logic [1:0] sel, input logic [12:0] raddr,
                              input logic chk_di, input logic [7:0] di);
    vec_t v;
    v.ab = ab; v.we = we; v.wd = wd; v.sel = sel; v.raddr = raddr; v.chk_di = chk_di;
    v.di = di;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    cpu_ab = v.ab;
    cpu_we = v.we;
    cpu_do = v.wd;
    @(negedge clk);
    chk($sformatf("%s_rdy", tag), 16'(cpu_rdy), 16'd1);
    chk($sformatf("%s_req", tag), 16'(io_bus.io_req), 16'd0);
    chk($sformatf("%s_rom_sel", tag), 16'(rom_sel), 16'(v.sel));
    chk($sformatf("%s_rom_addr", tag), 16'(rom_addr), 16'(v.raddr));
    if (v.chk_di) chk($sformatf("%s_di", tag), 16'(cpu_di), 16'(v.di));
  endtask

  task automatic idle_bus();
    @(posedge clk);
    #1;
    cpu_ab = 16'h0400;
    cpu_we = 1'b0;
    cpu_do = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset  = 1'b1;
    cpu_ab = 16'h0400;
    cpu_we = 1'b0;
    cpu_do = 8'h00;
    io_bus.io_ack   = 1'b0;
    io_bus.io_rdata = 8'h00;

    // Vectors common to both builds (port at its reset value: all of RAM/ROM/I/O visible).
    vecs.push_back(mk(16'h0400, 1, 8'h55, 2'd0, 13'h0400, 0, 8'h00));
    vecs.push_back(mk(16'h0400, 0, 8'h00, 2'd0, 13'h0400, 1, 8'h55));
    vecs.push_back(mk(16'hA000, 0, 8'h00, 2'd1, 13'h0000, 1, 8'hB1));
    vecs.push_back(mk(16'hBFFF, 0, 8'h00, 2'd1, 13'h1FFF, 1, 8'h4E));
    vecs.push_back(mk(16'hE000, 0, 8'h00, 2'd2, 13'h0000, 1, 8'hE2));
    vecs.push_back(mk(16'hFFFC, 0, 8'h00, 2'd2, 13'h1FFC, 1, 8'h1E));
    vecs.push_back(mk(16'hE010, 1, 8'h99, 2'd2, 13'h0010, 0, 8'h00));
    vecs.push_back(mk(16'hE010, 0, 8'h00, 2'd2, 13'h0010, 1, 8'hF2));
    vecs.push_back(mk(16'hA123, 1, 8'h77, 2'd1, 13'h0123, 0, 8'h00));
    vecs.push_back(mk(16'h9FFF, 1, 8'h11, 2'd0, 13'h1FFF, 0, 8'h00));
    vecs.push_back(mk(16'h9FFF, 0, 8'h00, 2'd0, 13'h1FFF, 1, 8'h11));
    vecs.push_back(mk(16'hC000, 1, 8'h3C, 2'd0, 13'h0000, 0, 8'h00));
    vecs.push_back(mk(16'hCFFF, 1, 8'hAA, 2'd0, 13'h0FFF, 0, 8'h00));
    vecs.push_back(mk(16'hC000, 0, 8'h00, 2'd0, 13'h0000, 1, 8'h3C));
    vecs.push_back(mk(16'hCFFF, 0, 8'h00, 2'd0, 13'h0FFF, 1, 8'hAA));
`ifdef C64_PORT_EN
    vecs.push_back(mk(16'h0001, 0, 8'h00, 2'd0, 13'h0001, 1, 8'h37));
    vecs.push_back(mk(16'h0000, 0, 8'h00, 2'd0, 13'h0000, 1, 8'h2F));
    vecs.push_back(mk(16'h0001, 1, 8'h35, 2'd0, 13'h0001, 0, 8'h00));
    vecs.push_back(mk(16'h0001, 0, 8'h00, 2'd0, 13'h0001, 1, 8'h35));
    vecs.push_back(mk(16'hE010, 0, 8'h00, 2'd0, 13'h0010, 1, 8'h99));
    vecs.push_back(mk(16'hA123, 0, 8'h00, 2'd0, 13'h0123, 1, 8'h77));
    vecs.push_back(mk(16'h0001, 1, 8'h33, 2'd0, 13'h0001, 0, 8'h00));
    vecs.push_back(mk(16'hD123, 0, 8'h00, 2'd3, 13'h0123, 1, 8'hE0));
    vecs.push_back(mk(16'h0001, 1, 8'h30, 2'd0, 13'h0001, 0, 8'h00));
    vecs.push_back(mk(16'hD123, 1, 8'h5E, 2'd0, 13'h1123, 0, 8'h00));
    vecs.push_back(mk(16'hD123, 0, 8'h00, 2'd0, 13'h1123, 1, 8'h5E));
    vecs.push_back(mk(16'h0001, 1, 8'h37, 2'd0, 13'h0001, 0, 8'h00));
`else
    vecs.push_back(mk(16'h0001, 1, 8'h00, 2'd0, 13'h0001, 0, 8'h00));
    vecs.push_back(mk(16'h0001, 0, 8'h00, 2'd0, 13'h0001, 1, 8'h00));
    vecs.push_back(mk(16'hA000, 0, 8'h00, 2'd1, 13'h0000, 1, 8'hB1));
    vecs.push_back(mk(16'hE001, 0, 8'h00, 2'd2, 13'h0001, 1, 8'hE3));
`endif

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rdy", 16'(cpu_rdy), 16'd1);
    chk("reset_req", 16'(io_bus.io_req), 16'd0);
    chk("reset_io_we", 16'(io_bus.io_we), 16'd0);
    chk("reset_io_addr", 16'(io_bus.io_addr), 16'h000);
    chk("reset_io_wdata", 16'(io_bus.io_wdata), 16'h00);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // I/O read with ack on the fourth wait cycle.
    @(posedge clk);
    #1 cpu_ab = 16'hD020; cpu_we = 1'b0;
    @(negedge clk);
    chk("iord_idle_rdy", 16'(cpu_rdy), 16'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      io_bus.io_ack   = (k == 3);
      io_bus.io_rdata = (k == 3) ? 8'h0E : 8'h00;
      @(negedge clk);
      chk($sformatf("iord_wait%0d_rdy", k), 16'(cpu_rdy), 16'd0);
      chk($sformatf("iord_wait%0d_req", k), 16'(io_bus.io_req), 16'd1);
      if (k == 0) begin
        chk("iord_addr", 16'(io_bus.io_addr), 16'h020);
        chk("iord_we", 16'(io_bus.io_we), 16'd0);
      end
    end
    @(posedge clk);
    #1 io_bus.io_ack = 1'b0; io_bus.io_rdata = 8'h00;
    @(negedge clk);
    chk("iord_done_rdy", 16'(cpu_rdy), 16'd1);
    chk("iord_done_req", 16'(io_bus.io_req), 16'd0);
    chk("iord_done_di", 16'(cpu_di), 16'h0E);
    // Stray ack while idle must not start anything.
    @(posedge clk);
    #1 cpu_ab = 16'h0400; io_bus.io_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_rdy", 16'(cpu_rdy), 16'd1);
    @(posedge clk);
    #1 io_bus.io_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req", 16'(io_bus.io_req), 16'd0);
    chk("stray_ack_rdy2", 16'(cpu_rdy), 16'd1);

    // I/O write acknowledged on the first wait cycle.
    @(posedge clk);
    #1 cpu_ab = 16'hD018; cpu_we = 1'b1; cpu_do = 8'h15;
    @(posedge clk);
    #1 io_bus.io_ack = 1'b1;
    @(negedge clk);
    chk("iowr_req", 16'(io_bus.io_req), 16'd1);
    chk("iowr_we", 16'(io_bus.io_we), 16'd1);
    chk("iowr_addr", 16'(io_bus.io_addr), 16'h018);
    chk("iowr_wdata", 16'(io_bus.io_wdata), 16'h15);
    @(posedge clk);
    #1 io_bus.io_ack = 1'b0;
    @(negedge clk);
    chk("iowr_done_rdy", 16'(cpu_rdy), 16'd1);
    chk("iowr_done_req", 16'(io_bus.io_req), 16'd0);
    idle_bus();

    // I/O read with no ack: times out after 16 cycles with 8'hFF.
    @(posedge clk);
    #1 cpu_ab = 16'hD400;
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!io_bus.io_req) break;
      cnt++;
      @(posedge clk);
    end
    chk("tmo_cycles", 16'(cnt), 16'd16);
    chk("tmo_done_rdy", 16'(cpu_rdy), 16'd1);
    chk("tmo_done_di", 16'(cpu_di), 16'hFF);
    idle_bus();
    @(negedge clk);
    chk("tmo_idle_req", 16'(io_bus.io_req), 16'd0);
    chk("tmo_idle_rdy", 16'(cpu_rdy), 16'd1);

    // Ack on the final timeout cycle wins over 8'hFF.
    @(posedge clk);
    #1 cpu_ab = 16'hD401;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      io_bus.io_ack   = (k == 15);
      io_bus.io_rdata = (k == 15) ? 8'h5A : 8'h00;
      @(negedge clk);
      if (k == 15) chk("lastack_req_held", 16'(io_bus.io_req), 16'd1);
    end
    @(posedge clk);
    #1 io_bus.io_ack = 1'b0; io_bus.io_rdata = 8'h00;
    @(negedge clk);
    chk("lastack_rdy", 16'(cpu_rdy), 16'd1);
    chk("lastack_di", 16'(cpu_di), 16'h5A);
    idle_bus();

    // Reset during WAIT of an I/O write.
    @(posedge clk);
    #1 cpu_ab = 16'hD000; cpu_we = 1'b1; cpu_do = 8'h12;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstwait_req_before", 16'(io_bus.io_req), 16'd1);
    @(posedge clk);
    #1 reset = 1'b0; cpu_ab = 16'h0400; cpu_we = 1'b0; cpu_do = 8'h00;
    @(negedge clk);
    chk("rstwait_req", 16'(io_bus.io_req), 16'd0);
    chk("rstwait_rdy", 16'(cpu_rdy), 16'd1);
    chk("rstwait_io_addr", 16'(io_bus.io_addr), 16'h000);
    chk("rstwait_io_we", 16'(io_bus.io_we), 16'd0);
    chk("rstwait_ram_kept", 16'(cpu_di), 16'h55);
`ifdef C64_PORT_EN
    run_vec("post_rst_port", mk(16'h0001, 0, 8'h00, 2'd0, 13'h0001, 1, 8'h37));
`else
    run_vec("post_rst_w01", mk(16'h0001, 1, 8'h00, 2'd0, 13'h0001, 0, 8'h00));
    run_vec("post_rst_basic", mk(16'hA000, 0, 8'h00, 2'd1, 13'h0000, 1, 8'hB1));
`endif
    idle_bus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
